sw_pattern_sequencer: RTL and testbench

Self-checking stimulus source for the lab's switch-driven combinational circuits. It drives every 7-bit switch pattern in ascending order into the switch inputs of a design under test and holds each pattern for a fixed number of cycles. It samples the design's 2-bit LED response once per pattern and tallies how many patterns lit each LED. It sits between the board clock/buttons and the `sw`/`led` ports of the circuit top-level, replacing manual switch flipping during bring-up.

---
 rtl/sw_pattern_sequencer.sv | 127 ++++++++++++
 tb/tb_sw_pattern_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pattern_sequencer.sv
// Walks every WIDTH-bit switch pattern in ascending order, holds each for HOLD_CYCLES,
// and tallies per-LED hit counts from the response sampled on the last hold cycle.
module sw_pattern_sequencer #(
    parameter int WIDTH       = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int RESP_WIDTH  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    input  logic [RESP_WIDTH-1:0]             resp_in,
    output logic [WIDTH-1:0]                  pattern_out,
    output logic                              busy,
    output logic                              done,
    output logic [RESP_WIDTH*(WIDTH+1)-1:0]   cnt
);

    // A one-bit hold counter is kept even for HOLD_CYCLES=1 so the compare stays legal
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CW = WIDTH + 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] PAT_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              done_q, done_d;
    logic [CW-1:0]     count_q [RESP_WIDTH];
    logic [CW-1:0]     count_d [RESP_WIDTH];
    logic              sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            hold_q    <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < RESP_WIDTH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            for (int i = 0; i < RESP_WIDTH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign sample = (hold_q == HOLD_LAST);

    // Abort outranks the sample, so an aborted sample cycle leaves the counts untouched
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hold_d    = hold_q;
        done_d    = done_q;
        for (int i = 0; i < RESP_WIDTH; i++) begin
            count_d[i] = count_q[i];
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = DRIVE;
                    pattern_d = '0;
                    hold_d    = '0;
                    done_d    = 1'b0;
                    for (int i = 0; i < RESP_WIDTH; i++) begin
                        count_d[i] = '0;
                    end
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d   = IDLE;
                    pattern_d = '0;
                    hold_d    = '0;
                    done_d    = 1'b0;
                end else if (sample) begin
                    for (int i = 0; i < RESP_WIDTH; i++) begin
                        if (resp_in[i]) begin
                            count_d[i] = count_q[i] + CW'(1);
                        end
                    end
                    hold_d = '0;
                    if (pattern_q == PAT_LAST) begin
                        state_d   = DONE;
                        pattern_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        pattern_d = pattern_q + WIDTH'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                pattern_d = '0;
                hold_d    = '0;
                done_d    = 1'b0;
            end
        endcase
    end

    assign pattern_out = pattern_q;
    assign busy        = (state_q == DRIVE);
    assign done        = done_q;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < RESP_WIDTH; i++) begin
            cnt[i*CW +: CW] = count_q[i];
        end
    end

endmodule

// File: tb/tb_sw_pattern_sequencer.sv
// Directed bench for sw_pattern_sequencer: full runs with several response loopbacks,
// abort, async reset and a HOLD_CYCLES=1 / WIDTH=3 instance.
module tb_sw_pattern_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  resp_in;
    logic [6:0]  pattern_out;
    logic        busy;
    logic        done;
    logic [15:0] cnt;

    logic        start_s;
    logic        abort_s;
    logic [1:0]  resp_s;
    logic [2:0]  pattern_s;
    logic        busy_s;
    logic        done_s;
    logic [7:0]  cnt_s;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    int cyc      = 0;

    typedef struct {
        int    mode;
        int    exp0;
        int    exp1;
        string name;
    } vec_t;

    vec_t vecs [5];

    sw_pattern_sequencer #(.WIDTH(7), .HOLD_CYCLES(4), .RESP_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .resp_in(resp_in),
        .pattern_out(pattern_out), .busy(busy), .done(done), .cnt(cnt)
    );

    sw_pattern_sequencer #(.WIDTH(3), .HOLD_CYCLES(1), .RESP_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .resp_in(resp_s),
        .pattern_out(pattern_s), .busy(busy_s), .done(done_s), .cnt(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response sources: loopback, constant, off-sample-only, and top-bit/last-pattern detect
    task automatic apply_stimulus();
        case (mode)
            0: resp_in = {pattern_out[1] & pattern_out[2], pattern_out[0]};
            1: resp_in = 2'b11;
            2: resp_in = (cyc % 4 == 3) ? 2'b00 : 2'b01;
            3: resp_in = {pattern_out == 7'h7f, pattern_out[6]};
            default: resp_in = 2'b00;
        endcase
        resp_s = {1'b0, pattern_s[2]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        apply_stimulus();
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic pulse_start(input int m);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        apply_stimulus();
    endtask

    task automatic run_full(input int m, input int e0, input int e1, input string tag);
        int busy_cycles;
        int seq_err;
        pulse_start(m);
        check_output({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check_output({tag, "_pattern_after_start"}, 32'(pattern_out), 32'd0);
        check_output({tag, "_done_after_start"}, 32'(done), 32'd0);
        check_output({tag, "_cnt_cleared"}, 32'(cnt), 32'd0);
        busy_cycles = 0;
        seq_err     = 0;
        while (busy && busy_cycles < 2000) begin
            busy_cycles++;
            if (int'(pattern_out) != cyc / 4) seq_err++;
            tick();
        end
        check_output({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd512);
        check_output({tag, "_pattern_sequence_errors"}, 32'(seq_err), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd1);
        check_output({tag, "_pattern_after_run"}, 32'(pattern_out), 32'd0);
        check_output({tag, "_field0"}, 32'(cnt[7:0]), 32'(e0));
        check_output({tag, "_field1"}, 32'(cnt[15:8]), 32'(e1));
        tick();
        tick();
        check_output({tag, "_field0_hold"}, 32'(cnt[7:0]), 32'(e0));
        check_output({tag, "_done_hold"}, 32'(done), 32'd1);
    endtask

    task automatic run_abort(input int pat, input int e0, input int e1, input string tag);
        int n;
        pulse_start(0);
        n = 0;
        while (cyc != pat * 4 + 3 && n < 2000) begin
            n++;
            tick();
        end
        check_output({tag, "_reached_abort_point"}, 32'(pattern_out), 32'(pat));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_pattern"}, 32'(pattern_out), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_field0"}, 32'(cnt[7:0]), 32'(e0));
        check_output({tag, "_field1"}, 32'(cnt[15:8]), 32'(e1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output({tag, "_abort_in_idle_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_abort_in_idle_field0"}, 32'(cnt[7:0]), 32'(e0));
    endtask

    initial begin
        int n;
        int seq_err;

        vecs[0] = '{mode: 0, exp0: 64,  exp1: 32,  name: "loopback"};
        vecs[1] = '{mode: 1, exp0: 128, exp1: 128, name: "const11"};
        vecs[2] = '{mode: 1, exp0: 128, exp1: 128, name: "const11_restart"};
        vecs[3] = '{mode: 2, exp0: 0,   exp1: 0,   name: "off_sample_only"};
        vecs[4] = '{mode: 3, exp0: 64,  exp1: 1,   name: "top_bit_last"};

        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        start_s = 1'b0;
        abort_s = 1'b0;
        resp_in = 2'b00;
        resp_s  = 2'b00;
        #3;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_pattern", 32'(pattern_out), 32'd0);
        check_output("reset_cnt", 32'(cnt), 32'd0);
        check_output("reset_small_busy", 32'(busy_s), 32'd0);
        #9;
        reset = 1'b0;
        tick();
        tick();
        check_output("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_full(vecs[i].mode, vecs[i].exp0, vecs[i].exp1, vecs[i].name);
        end

        run_abort(10, 5, 2, "abort_p10");
        run_abort(11, 5, 2, "abort_p11");

        pulse_start(0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_output("start_abort_together_busy", 32'(busy), 32'd0);

        pulse_start(0);
        for (int i = 0; i < 100; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_busy", 32'(busy), 32'd0);
        check_output("async_reset_pattern", 32'(pattern_out), 32'd0);
        check_output("async_reset_done", 32'(done), 32'd0);
        check_output("async_reset_cnt", 32'(cnt), 32'd0);
        #10;
        reset = 1'b0;
        tick();
        tick();
        check_output("post_reset_idle", 32'(busy), 32'd0);
        run_full(0, 64, 32, "after_reset");

        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        cyc = 0;
        apply_stimulus();
        n = 0;
        seq_err = 0;
        while (busy_s && n < 100) begin
            n++;
            if (int'(pattern_s) != cyc) seq_err++;
            start_s = (n == 3);
            tick();
        end
        start_s = 1'b0;
        check_output("small_busy_cycles", 32'(n), 32'd8);
        check_output("small_pattern_sequence_errors", 32'(seq_err), 32'd0);
        check_output("small_done", 32'(done_s), 32'd1);
        check_output("small_pattern_after_run", 32'(pattern_s), 32'd0);
        check_output("small_field0", 32'(cnt_s[3:0]), 32'd4);
        check_output("small_field1", 32'(cnt_s[7:4]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
